usb_bit_stuffer: RTL and testbench

//  Serial USB bit-stuffing stage that sits directly downstream of the CRC encoders
//  (CRC5/CRC16) and upstream of the NRZI encoder.

---
 rtl/usb_pkg.sv | 13 +
 rtl/usb_bit_stuffer_if.sv | 24 ++
 rtl/usb_bit_stuffer.sv | 107 ++++++++++
 tb/tb_usb_bit_stuffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB serial-path definitions: bit-stuffer states and the stuffing run length
// used by both the transmit stuffer and the receive unstuffer.
package usb_pkg;

  typedef enum logic [1:0] {
    BS_IDLE  = 2'd0,
    BS_PASS  = 2'd1,
    BS_STUFF = 2'd2
  } bs_state_t;

  localparam int USB_STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_bit_stuffer_if.sv
// Bit-stuffer serial interface: upstream bit stream with ready handshake in, stuffed
// stream out to the NRZI encoder (no backpressure on the output side).
interface usb_bit_stuffer_if;

  logic in_valid;
  logic in_bit;
  logic in_last;
  logic bs_ready;
  logic out_valid;
  logic out_bit;
  logic out_last;

  // Upstream encoder plus downstream NRZI, as seen from outside the stuffer
  modport master (
    output in_valid, in_bit, in_last,
    input  bs_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last,
    output bs_ready, out_valid, out_bit, out_last
  );

endinterface

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: one-cycle pass-through that inserts a 0 after every
// STUFF_LIMIT consecutive 1s and stalls upstream for that inserted bit.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int STUFF_LIMIT = USB_STUFF_LIMIT,
  parameter int CNT_W       = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  usb_bit_stuffer_if.slave bs
);

  bs_state_t         state_r;
  bs_state_t         state_s;
  logic [CNT_W-1:0]  ones_cnt_r;
  logic [CNT_W-1:0]  ones_cnt_s;
  logic              last_pend_r;
  logic              last_pend_s;
  logic              out_valid_r;
  logic              out_valid_s;
  logic              out_bit_r;
  logic              out_bit_s;
  logic              out_last_r;
  logic              out_last_s;
  logic              xfer_s;
  logic              run_done_s;

  assign bs.bs_ready  = (state_r != BS_STUFF);
  assign bs.out_valid = out_valid_r;
  assign bs.out_bit   = out_bit_r;
  assign bs.out_last  = out_last_r;

  assign xfer_s     = bs.in_valid && (state_r != BS_STUFF);
  assign run_done_s = bs.in_bit && (ones_cnt_r == CNT_W'(STUFF_LIMIT - 1));

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    ones_cnt_s  = ones_cnt_r;
    last_pend_s = last_pend_r;
    out_valid_s = 1'b0;
    out_bit_s   = out_bit_r;
    out_last_s  = 1'b0;
    case (state_r)
      BS_IDLE, BS_PASS: begin
        if (xfer_s) begin
          out_valid_s = 1'b1;
          out_bit_s   = bs.in_bit;
          ones_cnt_s  = bs.in_bit ? (ones_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
          if (run_done_s) begin
            // out_last is deferred to the stuff bit so it closes the packet
            state_s     = BS_STUFF;
            last_pend_s = bs.in_last;
            out_last_s  = 1'b0;
          end else if (bs.in_last) begin
            state_s     = BS_IDLE;
            out_last_s  = 1'b1;
            ones_cnt_s  = {CNT_W{1'b0}};
          end else begin
            state_s     = BS_PASS;
            out_last_s  = 1'b0;
          end
        end else begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end
      end
      BS_STUFF: begin
        out_valid_s = 1'b1;
        out_bit_s   = 1'b0;
        ones_cnt_s  = {CNT_W{1'b0}};
        out_last_s  = last_pend_r;
        last_pend_s = 1'b0;
        state_s     = last_pend_r ? BS_IDLE : BS_PASS;
      end
      default: begin
        state_s     = BS_IDLE;
        ones_cnt_s  = {CNT_W{1'b0}};
        last_pend_s = 1'b0;
        out_valid_s = 1'b0;
        out_bit_s   = 1'b0;
        out_last_s  = 1'b0;
      end
    endcase
  end

  // State, run counter and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= BS_IDLE;
      ones_cnt_r  <= {CNT_W{1'b0}};
      last_pend_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      ones_cnt_r  <= ones_cnt_s;
      last_pend_r <= last_pend_s;
      out_valid_r <= out_valid_s;
      out_bit_r   <= out_bit_s;
      out_last_r  <= out_last_s;
    end
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Directed self-checking bench for usb_bit_stuffer; output streams are captured
// LSB-first into packed words and compared against hand-computed vectors.
module tb_usb_bit_stuffer;
  import usb_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic obs_bits [0:511];
  logic obs_last [0:511];
  int   obs_n;
  int   rdy_low;

  usb_bit_stuffer_if bs ();

  usb_bit_stuffer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bs      (bs.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output capture and stall counting, sampled mid-cycle
  always @(negedge clock) begin
    if (reset_n && bs.out_valid && obs_n < 512) begin
      obs_bits[obs_n] <= bs.out_bit;
      obs_last[obs_n] <= bs.out_last;
      obs_n           <= obs_n + 1;
    end
    if (reset_n && !bs.bs_ready) rdy_low <= rdy_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present n bits (LSB first) and wait for each to be accepted
  task automatic send(input logic [31:0] bits, input int n, input logic last_flag);
    logic acc;
    int   tries;
    for (int i = 0; i < n; i++) begin
      bs.in_valid = 1'b1;
      bs.in_bit   = bits[i];
      bs.in_last  = last_flag && (i == n - 1);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 8) begin
        @(negedge clock);
        acc = bs.bs_ready;
        @(posedge clock);
        #1;
        tries++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
    bs.in_valid = 1'b0;
    bs.in_last  = 1'b0;
  endtask

  task automatic get_stream(input int base, output logic [31:0] bits,
                            output logic [31:0] lasts, output int n);
    bits  = 32'd0;
    lasts = 32'd0;
    n     = obs_n - base;
    for (int i = 0; i < n && i < 32; i++) begin
      bits[i]  = obs_bits[base + i];
      lasts[i] = obs_last[base + i];
    end
  endtask

  task automatic run_packet(input string tag, input logic [31:0] in_bits, input int n_in,
                            input logic [31:0] exp_bits, input logic [31:0] exp_last,
                            input int exp_n, input int exp_rdy);
    int          base;
    int          rdy0;
    int          n;
    logic [31:0] bits;
    logic [31:0] lasts;
    base = obs_n;
    rdy0 = rdy_low;
    send(in_bits, n_in, 1'b1);
    cycles(3);
    get_stream(base, bits, lasts, n);
    check({tag, "_count"}, 32'(n), 32'(exp_n));
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_last"}, lasts, exp_last);
    check({tag, "_stalls"}, 32'(rdy_low - rdy0), 32'(exp_rdy));
  endtask

  initial begin
    int          base;
    int          rdy0;
    int          n;
    int          snap;
    logic [31:0] bits;
    logic [31:0] lasts;
    n_checks    = 0;
    n_errors    = 0;
    obs_n       = 0;
    rdy_low     = 0;
    reset_n     = 1'b0;
    bs.in_valid = 1'b0;
    bs.in_bit   = 1'b0;
    bs.in_last  = 1'b0;

    #3;
    check("rst_out_valid", 32'(bs.out_valid), 32'd0);
    check("rst_out_bit", 32'(bs.out_bit), 32'd0);
    check("rst_out_last", 32'(bs.out_last), 32'd0);
    check("rst_bs_ready", 32'(bs.bs_ready), 32'd1);
    #20;
    reset_n = 1'b1;
    cycles(2);

    // 8 ones -> 1,1,1,1,1,1,0,1,1 with last on the 9th
    run_packet("t1", 32'hFF, 8, 32'h1BF, 32'h100, 9, 1);

    // 6 ones -> trailing stuff bit carries out_last
    run_packet("t2", 32'h3F, 6, 32'h3F, 32'h40, 7, 1);
    check("t2_idle", 32'(dut.state_r), 32'(BS_IDLE));

    // 1,1,1,1,1,0,1,1 -> unchanged
    run_packet("t3", 32'hDF, 8, 32'hDF, 32'h80, 8, 0);
    check("t3_cnt_clear", 32'(dut.ones_cnt_r), 32'd0);

    // Run split by a 4-cycle gap still stuffs after the sixth 1
    base = obs_n;
    rdy0 = rdy_low;
    send(32'h7, 3, 1'b0);
    cycles(1);
    check("t4_gap_valid", 32'(bs.out_valid), 32'd0);
    snap = obs_n;
    cycles(3);
    check("t4_gap_count", 32'(obs_n - snap), 32'd0);
    send(32'h7, 3, 1'b1);
    cycles(3);
    get_stream(base, bits, lasts, n);
    check("t4_count", 32'(n), 32'd7);
    check("t4_bits", bits, 32'h3F);
    check("t4_last", lasts, 32'h40);
    check("t4_stalls", 32'(rdy_low - rdy0), 32'd1);

    // 12 ones then back-to-back 6 ones: stuffs at 7, 14 and 21
    base = obs_n;
    rdy0 = rdy_low;
    send(32'hFFF, 12, 1'b1);
    send(32'h3F, 6, 1'b1);
    cycles(3);
    get_stream(base, bits, lasts, n);
    check("t5_count", 32'(n), 32'd21);
    check("t5_bits", bits, 32'hFDFBF);
    check("t5_last", lasts, 32'h102000);
    check("t5_stalls", 32'(rdy_low - rdy0), 32'd3);

    // Reset while in STUFF
    send(32'h3F, 6, 1'b0);
    check("t6_in_stuff", 32'(dut.state_r), 32'(BS_STUFF));
    check("t6_pre_valid", 32'(bs.out_valid), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bs.out_valid), 32'd0);
    check("t6_rst_last", 32'(bs.out_last), 32'd0);
    check("t6_rst_ready", 32'(bs.bs_ready), 32'd1);
    #10;
    reset_n = 1'b1;
    cycles(2);
    run_packet("t6_five", 32'h1F, 5, 32'h1F, 32'h10, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
